// File: rtl/and_reduce_arbiter.sv
// Round-robin shared AND-reduction engine: grants one requester per job,
// folds OPS words into a 1-bit reduction and returns it with the source port.
module and_reduce_arbiter #(
  parameter  int unsigned Port_Num = 2,
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned OPS      = 8,
  localparam int unsigned PW       = (Port_Num > 1) ? $clog2(Port_Num) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [Port_Num-1:0]       in_valid,
  input  logic [Port_Num*WIDTH-1:0] in_data,
  output logic [Port_Num-1:0]       in_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WIDTH-1:0]          res_q,
  output logic [PW-1:0]             res_port,
  output logic                      busy
);

  localparam int unsigned CW = $clog2(OPS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_grant;
  logic [PW-1:0]        r_rr_ptr;
  logic                 r_acc;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_res_q;
  logic [PW-1:0]        r_res_port;
  logic                 r_res_valid;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic [PW-1:0]        w_grant_nxt;
  logic [PW-1:0]        w_rr_ptr_nxt;
  logic                 w_acc_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [WIDTH-1:0]     w_res_q_nxt;
  logic [PW-1:0]        w_res_port_nxt;
  logic [PW-1:0]        w_win;
  logic [Port_Num-1:0]  w_grant_oh;
  logic [Port_Num-1:0]  w_in_ready;
  logic [WIDTH-1:0]     w_word;
  logic                 w_gvalid;
  logic                 w_fold;

  // Granted port's lane, its valid, and the running reduction including it
  assign w_grant_oh = Port_Num'(1) << r_grant;
  assign w_gvalid   = |(in_valid & w_grant_oh);
  assign w_word     = WIDTH'(in_data >> (32'(r_grant) * WIDTH));
  assign w_fold     = r_acc & (&w_word);

  // Round-robin pick: first requesting port at or after r_rr_ptr, wrapping
  always_comb begin
    logic                found;
    int unsigned         idx;
    logic [Port_Num-1:0] rot;
    w_win = r_rr_ptr;
    found = 1'b0;
    idx   = 0;
    rot   = '0;
    for (int unsigned i = 0; i < Port_Num; i++) begin
      idx = 32'(r_rr_ptr) + i;
      if (idx >= Port_Num) idx = idx - Port_Num;
      rot = in_valid >> idx;
      if (!found && rot[0]) begin
        found = 1'b1;
        w_win = PW'(idx);
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_acc_nxt      = r_acc;
    w_cnt_nxt      = r_cnt;
    w_res_q_nxt    = r_res_q;
    w_res_port_nxt = r_res_port;
    w_in_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (|in_valid) begin
          w_grant_nxt = w_win;
          w_acc_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_in_ready = w_grant_oh;
        if (w_gvalid) begin
          w_acc_nxt = w_fold;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(OPS - 1)) begin
            w_res_q_nxt    = WIDTH'(w_fold);
            w_res_port_nxt = r_grant;
            w_rr_ptr_nxt   = (r_grant == PW'(Port_Num - 1)) ? '0 : r_grant + PW'(1);
            w_state_nxt    = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_acc       <= 1'b1;
      r_cnt       <= '0;
      r_res_q     <= '0;
      r_res_port  <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_res_q     <= w_res_q_nxt;
      r_res_port  <= w_res_port_nxt;
      r_res_valid <= (w_state_nxt == S_RESULT);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign in_ready  = w_in_ready;
  assign res_valid = r_res_valid;
  assign res_q     = r_res_q;
  assign res_port  = r_res_port;
  assign busy      = r_busy;

endmodule

// File: tb/tb_and_reduce_arbiter.sv
// Directed bench for and_reduce_arbiter with a result scoreboard and a
// small round-robin reference model.
module tb_and_reduce_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned N  = 8;

  logic            clk;
  logic            rst_n;
  logic [NP-1:0]   in_valid;
  logic [NP*W-1:0] in_data;
  logic [NP-1:0]   in_ready;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_q;
  logic [0:0]      res_port;
  logic            busy;

  and_reduce_arbiter #(.Port_Num(NP), .WIDTH(W), .OPS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_q    (res_q),
    .res_port (res_port),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_err    = 0;
  int         q_port[$];
  logic [7:0] q_res[$];
  int         m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int arb(input logic [NP-1:0] v, input int rr);
    for (int i = 0; i < NP; i++) begin
      int idx;
      idx = (rr + i) % NP;
      if (v[idx]) return idx;
    end
    return rr;
  endfunction

  // Drive one job on port p; pushes the expected result before streaming.
  task automatic send_job(input int p, input logic [7:0] w [N], input bit gaps);
    int            idx, guard, viol, ep;
    bit            ph;
    logic          e;
    logic [NP-1:0] mask;
    idx = 0; guard = 0; viol = 0; ph = 1'b0; e = 1'b1;
    for (int i = 0; i < N; i++) e = e & (&w[i]);
    mask = NP'(1) << p;
    ep = arb(mask, m_rr);
    q_port.push_back(ep);
    q_res.push_back({7'd0, e});
    m_rr = (ep + 1) % NP;
    in_valid = '0;
    while (idx < N && guard < 100) begin
      if (!gaps || !ph) begin
        in_valid[p] = 1'b1;
        in_data[p*W +: W] = w[idx];
      end else begin
        in_valid[p] = 1'b0;
      end
      ph = !ph;
      if (in_ready[1-p]) viol++;
      if (in_valid[p] && in_ready[p]) idx++;
      @(negedge clk);
      guard++;
    end
    in_valid = '0;
    chk("job_words_accepted", idx, N);
    chk("other_port_ready_low", viol, 0);
    chk("res_valid_after_last_word", res_valid, 1'b1);
  endtask

  task automatic get_result();
    int g;
    g = 0;
    while (!res_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("res_valid_timeout", res_valid, 1'b1);
    chk("scoreboard_nonempty", q_port.size() != 0, 1'b1);
    if (q_port.size() != 0) begin
      chk("res_q", res_q, q_res.pop_front());
      chk("res_port", res_port, q_port.pop_front());
    end
  endtask

  logic [7:0] words [N];
  int         acc_cnt, g, t0, ep, viol;

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; res_ready = 1'b1; m_rr = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_q", res_q, 8'h00);
    chk("rst_res_port", res_port, 1'b0);
    chk("rst_in_ready", in_ready, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a port-1 job after three words
    in_valid = 2'b10; in_data = 16'hFF00;
    acc_cnt = 0; g = 0;
    while (acc_cnt < 3 && g < 50) begin
      if (in_valid[1] && in_ready[1]) acc_cnt++;
      @(negedge clk);
      g++;
    end
    chk("mid_job_accepts", acc_cnt, 3);
    chk("mid_job_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_res_valid", res_valid, 1'b0);
    chk("async_rst_res_q", res_q, 8'h00);
    chk("async_rst_in_ready", in_ready, 2'b00);
    in_valid = '0; m_rr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    words = '{default: 8'hFF};
    send_job(1, words, 1'b0);
    get_result();
    @(negedge clk);

    // All-ones job on port 0 with latency measurement
    t0 = cyc;
    send_job(0, words, 1'b0);
    chk("job_latency", cyc - t0, 9);
    get_result();
    @(negedge clk);

    // One cleared bit: full job still consumed, result zero
    words[1] = 8'hFE;
    send_job(0, words, 1'b0);
    get_result();
    @(negedge clk);
    words[1] = 8'hFF;

    // Result backpressure with a pending request during RESULT
    res_ready = 1'b0;
    send_job(0, words, 1'b0);
    get_result();
    in_valid = 2'b01; in_data = 16'h00FF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1'b1);
      chk("bp_res_q", res_q, 8'h01);
      chk("bp_res_port", res_port, 1'b0);
      chk("bp_in_ready", in_ready, 2'b00);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_res_valid", res_valid, 1'b0);
    @(negedge clk);
    chk("bp_regrant_busy", busy, 1'b1);
    chk("bp_regrant_ready", in_ready, 2'b01);
    send_job(0, words, 1'b0);
    get_result();
    @(negedge clk);

    // Alternating valid gaps on port 1
    send_job(1, words, 1'b1);
    get_result();
    @(negedge clk);

    // Both ports requesting continuously for four jobs
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_rr = 0;
    @(negedge clk);
    in_valid = 2'b11; in_data = 16'hFFFF;
    for (int j = 0; j < 4; j++) begin
      ep = arb(2'b11, m_rr);
      q_port.push_back(ep);
      q_res.push_back(8'h01);
      m_rr = (ep + 1) % NP;
      viol = 0; g = 0;
      while (!res_valid && g < 50) begin
        if (in_ready[1-ep]) viol++;
        @(negedge clk);
        g++;
      end
      chk("rr_other_ready_low", viol, 0);
      get_result();
      @(negedge clk);
    end
    in_valid = '0;
    chk("scoreboard_drained", q_port.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/and_reduce_arbiter.md
# and_reduce_arbiter

Sequential front end that shares one AND-reduction datapath among `Port_Num` requesters. Each requester streams a job of `OPS` operand words over a valid/ready handshake. The block grants one port per job in round-robin order and folds every accepted word into a running reduction. When the job ends it presents the reduced result, tagged with the source port, on a valid/ready output. It sits between operand producers and the result consumer, replacing the unshared one-shot combinational reducer.

## Interface
- `Port_Num`, default 2: number of requesters; ≥1.
- `WIDTH`, default 8: operand and result width; ≥1.
- `OPS`, default 8: words per job; ≥1.
- `PW`, derived as max(1, clog2(`Port_Num`)): port-index width.

Ports, clock and reset first:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset is asynchronous and active-low.
- `in_valid`, input, `Port_Num`: bit p means port p presents a word.
- `in_data`, input, `Port_Num*WIDTH`: port p occupies bits [p*WIDTH +: WIDTH].
- `in_ready`, output, `Port_Num`: bit p means port p's word is accepted this cycle.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: consumer accepts the result.
- `res_q`, output, `WIDTH`: bit 0 is the AND of every bit of every word in the job; bits [WIDTH-1:1] are 0.
- `res_port`, output, `PW`: index of the port that produced the result.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, BUSY, RESULT.
- **IDLE**
  - `in_ready` = 0.
  - If any `in_valid` bit is set, select the grant port by round-robin. Search starts at `rr_ptr` and wraps modulo `Port_Num`. The first set bit wins.
  - Register the winner as `grant`. Set `acc` to 1 and `cnt` to 0. Go to BUSY.
- **BUSY**
  - `in_ready[grant]` = 1. All other `in_ready` bits are 0.
  - An accept occurs on any cycle with `in_valid[grant]` high. On each accept, `acc` <= `acc` & (&word) and `cnt` <= `cnt`+1.
  - Valid gaps are allowed; `cnt` holds during a gap.
  - Other ports' valids are ignored and are never accepted.
  - On the accept with `cnt` == `OPS`-1: latch `res_q` = {0, `acc` & (&word)} and `res_port` = `grant`. Set `rr_ptr` = (`grant`+1) mod `Port_Num`. Go to RESULT.
  - Every job consumes exactly `OPS` words; a zero word does not end the job early.
- **RESULT**
  - `res_valid` = 1, with `res_q` and `res_port` stable.
  - On `res_valid` & `res_ready`, go to IDLE. No new grant is made in that cycle.
- Width rules:
  - `cnt` is clog2(`OPS`+1) bits.
  - `rr_ptr` and `grant` wrap from `Port_Num`-1 to 0.
  - A word's reduction covers all `WIDTH` bits.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `acc` = 1, `cnt` = 0, `rr_ptr` = 0, `grant` = 0.
  - `res_valid` = 0, `res_q` = 0, `res_port` = 0, `busy` = 0, all `in_ready` = 0.
  - A job interrupted by reset is discarded and no result is produced.
- Outputs are registered except `in_ready`, which decodes directly from state and `grant`.

## Timing
- **Arbitration:** one cycle. A valid seen in IDLE at edge k puts the block in BUSY after edge k. `in_ready` is high in cycle k+1.
- **Accepts:** at most one word per cycle.
- **Minimum job latency:** `res_valid` rises 1+`OPS` cycles after the first IDLE valid, given back-to-back valids.
- **Result to next job:** the `res_ready` handshake at edge m returns the block to IDLE. The earliest next grant is at edge m+1. Minimum job period is `OPS`+2 cycles.
- **Simultaneous requests:** exactly one grant. Port `rr_ptr` wins if requesting; otherwise the next requesting index in ascending, wrapping order.
- **`res_ready` held high:** does not shorten the RESULT cycle; RESULT lasts at least one cycle.
- **Request valids while in RESULT:** ignored. They are re-evaluated in IDLE.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-BUSY, after 3 of 8 words, then release. Then send 8 all-ones words on port 1.
  - Required response: on reset, `busy`=0, `res_valid`=0, `res_q`=0, `in_ready`=0 immediately, with no edge needed. The next job completes with `res_q`=1, `res_port`=1.
- **All-ones job:**
  - Stimulus: port 0 sends 8 words of 8'hFF back-to-back.
  - Required response: `res_valid` rises 9 cycles after the first valid, with `res_q`=8'h01 and `res_port`=0.
- **Zero bit, no early exit:**
  - Stimulus: port 0 sends 8'hFF, 8'hFE, then six 8'hFF.
  - Required response: all 8 words are accepted, then `res_q`=8'h00.
- **Round-robin:**
  - Stimulus: both ports hold valid with 8'hFF data continuously for 4 jobs.
  - Required response: `res_port` sequence is 0,1,0,1. The non-granted port's `in_ready` stays 0 throughout each job.
- **Backpressure:**
  - Stimulus: hold `res_ready`=0 for 5 cycles after `res_valid` rises.
  - Required response: `res_valid`, `res_q` and `res_port` stay stable. The block returns to IDLE one edge after `res_ready`=1, and the next grant comes one edge after that.
- **Valid gaps:**
  - Stimulus: port 1 sends words with valid toggling 1,0,1,0…
  - Required response: `cnt` advances only on accepts. The result appears after exactly 8 accepted words, with `res_port`=1.
